// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the fetch
// path and the load/store path of a multi-cycle core.
//
// Each access runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP.
// When both ports request, the port that did not win the previous grant
// goes first. Read data is registered per port and comes with a one-cycle
// ready pulse.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr                    fetch request (held until if_ready)
//   if_rdata/if_ready                 fetch data (registered) and completion pulse
//   d_req/d_we/d_wstrb/d_addr/d_wdata data request (held until d_ready)
//   d_rdata/d_ready                   load data (registered) and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory access, decoded from state
//   mem_rdata                         memory read data, valid MEM_LAT cycles after mem_en
//   busy                              high whenever not IDLE
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,   // legal range 1..15 (4-bit wait counter)
  localparam int SW     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [SW-1:0]     d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic [SW-1:0]     mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  // WAIT lasts MEM_LAT cycles: load MEM_LAT-1 and leave when it hits zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state;
  logic              own_d;    // current owner: 1 = data, 0 = fetch
  logic              last_d;   // owner of the previous grant
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [SW-1:0]     wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic              grant_d;

  // Data wins if it is alone, or if both request and fetch had the last turn.
  always_comb grant_d = d_req && (!if_req || !last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      last_d   <= 1'b0;
      own_d    <= 1'b0;
      cnt      <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            own_d   <= grant_d;
            last_d  <= grant_d;
            addr_q  <= grant_d ? d_addr : if_addr;
            we_q    <= grant_d && d_we;
            wstrb_q <= d_wstrb;
            wdata_q <= d_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // mem_rdata is valid in this last WAIT cycle; ready rises with RESP.
            state <= RESP;
            if (own_d) begin
              d_ready <= 1'b1;
              if (!we_q) d_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is a pure decode of registered state, so a write whose ACCESS
  // cycle coincides with reset still reaches the memory.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS && own_d && we_q) ? wstrb_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a MEM_LAT=1 instance driven by directed
// and random transaction sequences against a transaction-level model, plus a
// MEM_LAT=3 instance for the latency case.
module tb_mem_arbiter;
  localparam int L0 = 1;

  logic clk, rst;
  int total = 0, bad = 0;

  // MEM_LAT=1 instance
  logic        if_req, d_req, d_we;
  logic [9:0]  if_addr, d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic [31:0] if_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic        if_ready0, d_ready0, mem_en0, busy0;
  logic [3:0]  mem_we0;
  logic [9:0]  mem_addr0;

  // MEM_LAT=3 instance (fetch only)
  logic        if_req1, z_req1, z_we1;
  logic [9:0]  if_addr1, z_addr1;
  logic [3:0]  z_wstrb1;
  logic [31:0] z_wdata1;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic        if_ready1, d_ready1, mem_en1, busy1;
  logic [3:0]  mem_we1;
  logic [9:0]  mem_addr1;

  // backdoor preload of both memories
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;

  logic [31:0] mem0 [0:15];
  logic [31:0] mem1 [0:15];
  logic [31:0] p1, p2;

  // model state
  logic [31:0] ref_mem [0:15];
  bit          m_last_d;
  logic [31:0] m_if_rdata, m_d_rdata;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata0), .if_ready(if_ready0),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_ready(d_ready0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0));

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .d_req(z_req1), .d_we(z_we1), .d_wstrb(z_wstrb1), .d_addr(z_addr1), .d_wdata(z_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories; read data is junk outside its valid cycle so a
  // mistimed capture shows up.
  always @(posedge clk) begin
    if (pl_en) mem0[pl_addr] <= pl_data;
    else if (mem_en0)
      for (int b = 0; b < 4; b++)
        if (mem_we0[b]) mem0[mem_addr0[3:0]][8*b +: 8] <= mem_wdata0[8*b +: 8];
    mem_rdata0 <= mem_en0 ? mem0[mem_addr0[3:0]] : $urandom;
  end

  always @(posedge clk) begin
    if (pl_en) mem1[pl_addr] <= pl_data;
    p1         <= mem_en1 ? mem1[mem_addr1[3:0]] : $urandom;
    p2         <= p1;
    mem_rdata1 <= p2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_f();
    if_addr = 10'($urandom_range(0, 15));
  endtask

  task automatic new_d();
    d_addr  = 10'($urandom_range(0, 15));
    d_we    = 1'($urandom_range(0, 1));
    d_wstrb = 4'($urandom_range(1, 15));
    d_wdata = $urandom;
  endtask

  task automatic model_reset();
    m_last_d   = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
  endtask

  // Runs nf fetch reads and nd data accesses on dut0, each requester holding
  // req across its own transactions. Starts in an IDLE cycle (cycle 0) and
  // ends in the IDLE cycle after the last RESP. Each access occupies
  // ACCESS, L0 WAIT cycles and RESP, followed by one IDLE sampling cycle.
  task automatic run_seq(input int nf, input int nd, input bit rnd);
    int rem_f = nf, rem_d = nd, cyc = 0, acc_c = 1, rdy_c;
    bit od, wr;
    logic [3:0]  a, ws;
    logic [31:0] wd, exp_rd;
    if (rnd) begin new_f(); new_d(); end
    if_req = (nf > 0);
    d_req  = (nd > 0);
    while (rem_f > 0 || rem_d > 0) begin
      od = (rem_d > 0) && (rem_f == 0 || !m_last_d);
      m_last_d = od;
      a  = od ? d_addr[3:0] : if_addr[3:0];
      wr = od && d_we;
      ws = d_wstrb;
      wd = d_wdata;
      exp_rd = ref_mem[a];
      if (wr)
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      rdy_c = acc_c + 1 + L0;
      while (cyc < rdy_c) begin
        step();
        cyc++;
        chk("mem_en", 32'(mem_en0), 32'(cyc == acc_c));
        chk("mem_we", 32'(mem_we0), (cyc == acc_c && wr) ? 32'(ws) : 32'd0);
        chk("busy", 32'(busy0), 32'(cyc >= acc_c));
        if (cyc == acc_c) begin
          chk("mem_addr", 32'(mem_addr0), 32'(a));
          if (wr) chk("mem_wdata", mem_wdata0, wd);
          // owner's inputs are don't-care once latched
          if (od) begin d_addr = 10'($urandom); d_wdata = $urandom; d_wstrb = 4'($urandom); end
          else if_addr = 10'($urandom);
        end
        if (cyc == rdy_c && !wr) begin
          if (od) m_d_rdata = exp_rd; else m_if_rdata = exp_rd;
        end
        chk("if_ready", 32'(if_ready0), 32'(cyc == rdy_c && !od));
        chk("d_ready", 32'(d_ready0), 32'(cyc == rdy_c && od));
        chk("if_rdata", if_rdata0, m_if_rdata);
        chk("d_rdata", d_rdata0, m_d_rdata);
      end
      if (od) begin
        rem_d--;
        if (rem_d == 0) d_req = 1'b0; else new_d();
      end else begin
        rem_f--;
        if (rem_f == 0) if_req = 1'b0; else new_f();
      end
      acc_c = rdy_c + 2;
    end
    step();
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_mem_en", 32'(mem_en0), 32'd0);
    chk("idle_ready", {30'd0, if_ready0, d_ready0}, 32'd0);
  endtask

  initial begin
    logic [31:0] ref7;
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wstrb = '0; d_wdata = '0;
    if_req1 = 0; if_addr1 = '0; z_req1 = 0; z_we1 = 0; z_addr1 = '0; z_wstrb1 = '0; z_wdata1 = '0;
    pl_en = 1'b1; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 16; i++) begin
      pl_addr = 4'(i);
      pl_data = (i == 5) ? 32'h0001F000 : (i == 2) ? 32'h11223344 : $urandom;
      ref_mem[i] = pl_data;
      step();
    end
    pl_en = 1'b0;
    model_reset();
    ref7 = ref_mem[7];

    // reset state
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_ready", {28'd0, if_ready0, d_ready0, if_ready1, d_ready1}, 32'd0);
    chk("rst_if_rdata", if_rdata0, 32'd0);
    chk("rst_d_rdata", d_rdata0, 32'd0);
    chk("rst_mem_en", {30'd0, mem_en0, mem_en1}, 32'd0);
    rst = 1'b0;

    // MEM_LAT=3: ACCESS in cycle 1, ready in cycle 5
    if_addr1 = 10'd7;
    if_req1  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("l3_mem_en", 32'(mem_en1), 32'(c == 1));
      chk("l3_ready", 32'(if_ready1), 32'(c == 5));
      chk("l3_busy", 32'(busy1), 32'(c <= 5));
      chk("l3_rdata", if_rdata1, (c >= 5) ? ref7 : 32'd0);
      if (c == 5) if_req1 = 1'b0;
    end

    // single fetch read
    if_addr = 10'd5;
    run_seq(1, 0, 1'b0);
    chk("t1_rdata", if_rdata0, 32'h0001F000);

    // full write then read back
    d_we = 1'b1; d_wstrb = 4'hF; d_addr = 10'd0; d_wdata = 32'h000F1000;
    run_seq(0, 1, 1'b0);
    chk("t2_d_rdata_after_wr", d_rdata0, 32'd0);
    d_we = 1'b0; d_addr = 10'd0;
    run_seq(0, 1, 1'b0);
    chk("t2_readback", d_rdata0, 32'h000F1000);

    // byte-strobe write
    d_we = 1'b1; d_wstrb = 4'b0010; d_addr = 10'd2; d_wdata = 32'hAABBCCDD;
    run_seq(0, 1, 1'b0);
    if_addr = 10'd2;
    run_seq(1, 0, 1'b0);
    chk("t3_bytewr", if_rdata0, 32'h1122CC44);

    // contention straight from reset release: data, fetch, data, fetch
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    run_seq(2, 2, 1'b1);

    // random mixes
    for (int it = 0; it < 25; it++) begin
      int nf, nd;
      nf = $urandom_range(0, 3);
      nd = $urandom_range(0, 3);
      if (nf == 0 && nd == 0) nd = 1;
      run_seq(nf, nd, 1'b1);
    end

    // reset during WAIT of a fetch: abandoned, no ready
    if_addr = 10'd3; if_req = 1'b1;
    step();
    chk("mr_mem_en", 32'(mem_en0), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; if_req = 1'b0;
    model_reset();
    chk("mr_busy", 32'(busy0), 32'd0);
    chk("mr_if_ready", 32'(if_ready0), 32'd0);
    chk("mr_if_rdata", if_rdata0, 32'd0);
    step();
    chk("mr_if_ready2", 32'(if_ready0), 32'd0);
    run_seq(1, 0, 1'b1);

    // reset coinciding with a write's ACCESS: write still lands
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wstrb = 4'hF; d_wdata = 32'h5A5AA5A5;
    step();
    chk("rw_mem_we", 32'(mem_we0), 32'hF);
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b0;
    ref_mem[9] = 32'h5A5AA5A5;
    model_reset();
    chk("rw_busy", 32'(busy0), 32'd0);
    chk("rw_d_ready", 32'(d_ready0), 32'd0);
    step();
    d_we = 1'b0; d_addr = 10'd9;
    run_seq(0, 1, 1'b0);
    chk("rw_readback", d_rdata0, 32'h5A5AA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for a single-port synchronous memory shared by the multi-cycle core's instruction-fetch path and its load/store path.
- Sits between the core's fetch and memory stages and one unified word-addressed memory.
- Serialises accesses, alternates fairly under contention and inserts the memory's read latency.
- Returns registered read data with a one-cycle ready pulse.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide.
- MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal values are 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetch data; registered.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_wstrb  in  DATA_W/8  byte enables for a write.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data; registered.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe.
- mem_we  out  DATA_W/8  byte write enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States and transitions:
  - IDLE: sample requests. With any request pending, latch owner, address, we, wstrb and wdata, then go to ACCESS.
  - ACCESS: lasts 1 cycle, then WAIT.
  - WAIT: lasts MEM_LAT cycles, counted by a 4-bit down-counter, then RESP.
  - RESP: lasts 1 cycle, then IDLE.
- Memory side:
  - mem_en is 1 only in ACCESS.
  - mem_addr and mem_wdata come from the latched values.
  - mem_we equals the latched wstrb only in ACCESS when the owner is data and we = 1; otherwise 0.
  - All memory outputs are decoded from the state register, not from the inputs.
- Capture and ready:
  - At the edge ending the last WAIT cycle, a read loads mem_rdata into the owner's rdata register.
  - The owner's ready is high for exactly the RESP cycle.
  - A write also pulses d_ready but leaves d_rdata unchanged.
  - The non-owner's rdata is untouched.
- Latency: a request seen in IDLE in cycle 0 gives ACCESS in cycle 1 and ready in cycle 2+MEM_LAT. With MEM_LAT=1, ready is in cycle 3 and the next grant is possible in cycle 4, so back-to-back throughput is one access per 3+MEM_LAT cycles.
- Arbitration:
  - A single request is granted directly.
  - When both requests are pending in IDLE, the port that is not last_owner is granted.
  - last_owner updates at each grant; its reset value is fetch, so the first contended grant goes to data.
  - Requests are sampled only in IDLE. Requester inputs changing in ACCESS, WAIT or RESP have no effect.
  - A requester that keeps req high through its RESP cycle is treated as issuing a new request in the following IDLE.
- Reset: when rst is high at an edge, the block goes to IDLE and sets if_ready = d_ready = 0, if_rdata = d_rdata = 0, last_owner = fetch and the counter to 0.
- Reset mid-operation:
  - A transaction in progress is abandoned and produces no ready pulse.
  - A write whose ACCESS cycle coincides with rst high still commits, because mem_we is decoded from the current state.
- Address: no range check; mem_addr passes through unchanged.

Test Plan:
- Single read, MEM_LAT=1: memory word 5 = 0x0001F000; if_req with if_addr=5 in cycle 0 -> mem_en high in cycle 1, if_ready high only in cycle 3, if_rdata=0x0001F000 from cycle 3 on, busy=0 in cycle 4.
- Full write then read: d_req, d_we=1, d_wstrb=4'hF, d_addr=0, d_wdata=0x000F1000 -> mem_we=4'hF in ACCESS only, d_ready in cycle 3, d_rdata stays 0; a following read of address 0 returns 0x000F1000.
- Byte-strobe write: memory word 2 = 0x11223344; write with d_wstrb=4'b0010 and d_wdata=0xAABBCCDD -> a later read of word 2 returns 0x1122CC44.
- Contention: if_req and d_req both held from reset release -> grant order is data, fetch, data, fetch; each ready comes 4 cycles after the previous one with MEM_LAT=1; neither port waits more than one transaction.
- Latency sweep, MEM_LAT=3: one read -> ready in cycle 5; mem_rdata is captured from cycle 4.
- Reset mid-operation: assert rst during WAIT of a fetch -> no if_ready, busy=0 and if_rdata=0 on the next cycle; the next request completes normally.
